// File: rtl/vmicro16_ifetch.sv
// vmicro16_ifetch: instruction fetch stage feeding vmicro16_dec.
// Owns the PC and reads a one-cycle-latency instruction BRAM. Returned words
// are queued with their PCs and handed to decode over a valid/ready handshake.
// An execute-stage redirect flushes the queue and drops any wrong-path read.
//
// Ports:
//   clk          clock, all state on rising edge
//   reset        asynchronous active-low reset
//   imem_addr    BRAM word address (the PC register)
//   imem_rd_en   BRAM read request (combinational), data returns next cycle
//   imem_data    BRAM read data
//   br_taken     redirect pulse from execute
//   br_target    redirect word address
//   instr        queue head instruction word
//   instr_pc     PC of queue head
//   instr_valid  queue non-empty
//   instr_ready  decode accepts the head this cycle
`timescale 1ns/1ps
module vmicro16_ifetch #(
  parameter int unsigned            DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0]  PC_RESET   = '0,
  parameter int unsigned            BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] imem_addr,
  output logic                  imem_rd_en,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  br_taken,
  input  logic [DATA_WIDTH-1:0] br_target,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] tag_q, tag_d;
  logic                  inflight_q, inflight_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] buf_data_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] buf_pc_q   [BUF_DEPTH];

  logic                  pop_c;
  logic                  push_c;
  logic [OCC_W-1:0]      occ_after_pop_c;

  // Queue head and handshake
  assign instr_valid = (count_q != '0);
  assign instr       = buf_data_q[rd_ptr_q];
  assign instr_pc    = buf_pc_q[rd_ptr_q];
  assign imem_addr   = pc_q;
  assign pop_c       = instr_valid & instr_ready;

  // Credit rule: a read may issue only if its word is guaranteed a free slot
  // when it returns, counting the word already in flight.
  assign occ_after_pop_c = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop_c);
  assign imem_rd_en      = reset & ~br_taken & (occ_after_pop_c < OCC_W'(BUF_DEPTH));

  // A returning word is dropped when a redirect lands on the same edge; the
  // redirect also clears inflight, so nothing from the old path arrives later.
  assign push_c = inflight_q & ~br_taken;

  // Next-state logic
  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = inflight_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (br_taken) begin
      pc_d       = br_target;
      inflight_d = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      inflight_d = imem_rd_en;
      if (imem_rd_en) begin
        tag_d = pc_q;
        pc_d  = pc_q + DATA_WIDTH'(1);
      end
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= PC_RESET;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Instruction queue storage; cleared on reset so instr/instr_pc read zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        buf_data_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else if (push_c) begin
      buf_data_q[wr_ptr_q] <= imem_data;
      buf_pc_q[wr_ptr_q]   <= tag_q;
    end
  end

endmodule

// File: tb/tb_vmicro16_ifetch.sv
`timescale 1ns/1ps
module tb_vmicro16_ifetch;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] imem_addr, imem_data;
  logic          imem_rd_en;
  logic          br_taken;
  logic [DW-1:0] br_target;
  logic [DW-1:0] instr, instr_pc;
  logic          instr_valid, instr_ready;

  logic [DW-1:0] imem_addr_w, imem_data_w;
  logic          imem_rd_en_w;
  logic [DW-1:0] instr_w, instr_pc_w;
  logic          instr_valid_w;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: PC, queue of delivered-order PCs, one in-flight read
  logic [DW-1:0] m_pc;
  logic [DW-1:0] m_q[$];
  bit            m_infl;
  logic [DW-1:0] m_infl_pc;

  bit wrap_en = 1'b0;
  int wrap_n  = 0;

  always #5 clk = ~clk;

  vmicro16_ifetch #(.DATA_WIDTH(DW), .PC_RESET(16'h0000), .BUF_DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd_en(imem_rd_en),
    .imem_data(imem_data), .br_taken(br_taken), .br_target(br_target),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  vmicro16_ifetch #(.DATA_WIDTH(DW), .PC_RESET(16'hFFFE), .BUF_DEPTH(DEPTH)) u_dut_w (
    .clk(clk), .reset(reset), .imem_addr(imem_addr_w), .imem_rd_en(imem_rd_en_w),
    .imem_data(imem_data_w), .br_taken(br_taken), .br_target(br_target),
    .instr(instr_w), .instr_pc(instr_pc_w), .instr_valid(instr_valid_w),
    .instr_ready(instr_ready)
  );

  function automatic logic [DW-1:0] mem_word(input logic [DW-1:0] a);
    return 16'hA000 + a;
  endfunction

  // Synchronous BRAMs, one-cycle read latency, mem[i] = A000 + i
  always @(posedge clk) begin
    if (imem_rd_en)   imem_data   <= mem_word(imem_addr);
    if (imem_rd_en_w) imem_data_w <= mem_word(imem_addr_w);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = 16'h0000;
    m_q.delete();
    m_infl = 1'b0;
    m_infl_pc = '0;
  endtask

  // One clock cycle: drive inputs at negedge, compare, then advance the model
  // to what the coming rising edge must produce.
  task automatic step(input bit rst, input bit br, input logic [DW-1:0] tgt, input bit rdy);
    bit            pop;
    bit            exp_rd;
    int            occ;
    logic [DW-1:0] dropped;
    @(negedge clk);
    reset       = rst;
    br_taken    = br;
    br_target   = tgt;
    instr_ready = rdy;
    #1;
    pop    = rst && (m_q.size() != 0) && rdy;
    occ    = m_q.size() + int'(m_infl);
    exp_rd = rst && !br && ((occ - int'(pop)) < int'(DEPTH));
    check("rd_en", 32'(imem_rd_en), 32'(exp_rd));
    check("imem_addr", 32'(imem_addr), 32'(m_pc));
    check("instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("instr_pc", 32'(instr_pc), 32'(m_q[0]));
      check("instr", 32'(instr), 32'(mem_word(m_q[0])));
    end
    check("no_overflow", 32'(32'(u_dut.count_q) <= DEPTH), 32'd1);
    if (wrap_en && rst && instr_valid_w && rdy && wrap_n < 4) begin
      check("wrap_pc", 32'(instr_pc_w), 32'(16'(16'hFFFE + 16'(wrap_n))));
      check("wrap_instr", 32'(instr_w), 32'(mem_word(16'(16'hFFFE + 16'(wrap_n)))));
      wrap_n++;
    end
    if (rst) begin
      if (br) begin
        m_q.delete();
        m_infl = 1'b0;
        m_pc   = tgt;
      end else begin
        if (pop) dropped = m_q.pop_front();
        if (m_infl) m_q.push_back(m_infl_pc);
        m_infl = exp_rd;
        if (exp_rd) begin
          m_infl_pc = m_pc;
          m_pc      = m_pc + 16'd1;
        end
      end
    end
  endtask

  initial begin
    bit            r_br, r_rdy;
    logic [DW-1:0] r_tgt;
    reset = 1'b0; br_taken = 1'b0; br_target = '0; instr_ready = 1'b0;
    model_reset();
    #1;
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_instr_pc", 32'(instr_pc), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_rd_en", 32'(imem_rd_en), 32'd0);

    // Redirects while in reset are ignored
    repeat (3) step(1'b0, 1'b1, 16'h1234, 1'b1);

    // Streaming from reset; wrap instance delivers FFFE, FFFF, 0000, 0001
    wrap_en = 1'b1;
    repeat (10) step(1'b1, 1'b0, '0, 1'b1);
    wrap_en = 1'b0;
    check("wrap_count", 32'(wrap_n), 32'd4);

    // Backpressure until full, then release
    repeat (6) step(1'b1, 1'b0, '0, 1'b0);
    repeat (4) step(1'b1, 1'b0, '0, 1'b1);

    // Redirect with a read in flight
    step(1'b1, 1'b1, 16'h0040, 1'b1);
    repeat (6) step(1'b1, 1'b0, '0, 1'b1);

    // Full buffer, pop and redirect on the same edge
    repeat (5) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 16'h0100, 1'b1);
    repeat (5) step(1'b1, 1'b0, '0, 1'b1);

    // Randomized ready/redirect traffic
    for (int i = 0; i < 3000; i++) begin
      r_rdy = ($urandom_range(0, 9) < 7);
      r_br  = ($urandom_range(0, 19) == 0);
      r_tgt = 16'($urandom);
      step(1'b1, r_br, r_tgt, r_rdy);
    end

    // Asynchronous reset between edges with the buffer full
    repeat (6) step(1'b1, 1'b0, '0, 1'b0);
    check("pre_async_valid", 32'(instr_valid), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_valid", 32'(instr_valid), 32'd0);
    check("async_rd_en", 32'(imem_rd_en), 32'd0);
    check("async_instr", 32'(instr), 32'd0);
    check("async_addr", 32'(imem_addr), 32'd0);
    model_reset();
    repeat (2) step(1'b0, 1'b0, '0, 1'b1);
    repeat (12) step(1'b1, 1'b0, '0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vmicro16_ifetch.md
Name: vmicro16_ifetch

Overview:
Instruction fetch stage directly upstream of vmicro16_dec. It owns the program counter and issues word reads to a synchronous instruction BRAM with one-cycle read latency. It buffers the returned instruction words with their PCs and hands them to decode over a valid/ready handshake. It also accepts branch redirects from the execute stage and squashes any wrong-path fetches.

Parameters:
DATA_WIDTH, 16, instruction word and PC width
PC_RESET, 16'h0000, PC value after reset (word address)
BUF_DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
imem_addr  output  DATA_WIDTH  BRAM word address, equals internal PC register
imem_rd_en  output  1  read request this cycle; data returns next cycle
imem_data  input  DATA_WIDTH  BRAM read data, valid the cycle after imem_rd_en
br_taken  input  1  redirect request from execute, single-cycle pulse
br_target  input  DATA_WIDTH  redirect word address, sampled when br_taken=1
instr  output  DATA_WIDTH  instruction word to decode (buffer head)
instr_pc  output  DATA_WIDTH  PC of instr
instr_valid  output  1  buffer non-empty
instr_ready  input  1  decode accepts head this cycle

Behaviour:
- Reset (reset=0, async): pc=PC_RESET, buffer empty, inflight=0, instr_valid=0, instr=0, instr_pc=0, imem_rd_en=0. State is released on the first clk edge with reset=1.
- pop = instr_valid & instr_ready. occupancy = buffer count + inflight (0/1).
- imem_rd_en (combinational) = reset & ~br_taken & (occupancy - pop < BUF_DEPTH).
- On issue: inflight<=1 and the issued PC is captured in a tag register. pc <= pc+1 modulo 2^DATA_WIDTH, so 16'hFFFF wraps to 16'h0000.
- Response: the cycle after an issue, {imem_data, tag} is pushed into the buffer, unless squashed. inflight<=0 unless a new issue occurs in the same cycle.
- Latency: with instr_ready=1, instr_valid rises 2 cycles after the first issue cycle. Steady-state throughput is 1 instr/cycle.
- Simultaneous push and pop is legal in any state, including full. A push into a full buffer is impossible by the credit rule; the bench asserts this.
- Backpressure: while instr_ready=0, instr and instr_pc hold stable. Fetch stops once occupancy reaches BUF_DEPTH, and no word is lost or duplicated.
- Redirect (br_taken=1 at edge):
  - buffer flushed (count<=0)
  - pc<=br_target
  - no issue that cycle
  - any response arriving next cycle discarded (squash flag)
  - inflight<=0
  - first target fetch issues the following cycle; instr_valid is 0 for at least 2 cycles after the redirect edge.
- br_taken takes priority over pop in the same cycle; the popped instruction is considered consumed by decode.
- br_taken during reset is ignored.
- Reset asserted mid-operation: outputs go to reset values immediately, without waiting for clk. The BRAM response after reset release is never pushed.
- PC arithmetic is unsigned DATA_WIDTH-bit; no alignment checks.

Test Plan:
- Reset release, BRAM holds mem[i]=16'hA000+i, instr_ready=1 → instr_valid rises 2 cycles after first imem_rd_en; instr/instr_pc = A000/0000, A001/0001, A002/0002 on consecutive cycles.
- Hold instr_ready=0 for 6 cycles after first valid → instr=A000, instr_pc=0000 stable; imem_rd_en low once occupancy=2; on release, PCs 0000,0001,0002 follow with no gaps or duplicates.
- br_taken with br_target=16'h0040 while PC 0003 is in flight → no instr_pc 0003/0004 ever appears; next instr_valid shows instr_pc=0040, instr=A040.
- PC_RESET=16'hFFFE → instr_pc sequence FFFE, FFFF, 0000, 0001.
- Full buffer with instr_ready=1 and br_taken=1 in the same cycle → buffer flushed; next delivered instr_pc = br_target; no overflow assertion fires.
- reset driven low between clock edges with buffer full → instr_valid=0 and imem_rd_en=0 before the next edge; after release, fetch restarts at PC_RESET.
